// File: rtl/fpu_lzd_pkg.sv
// Shared types and helpers for the FPU leading-zero detect / normalise blocks.
package fpu_lzd_pkg;

  localparam int LZD_MAX_W = 64;

  function automatic int lzd_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int LZD_MAX_CNT_W = lzd_cnt_w(LZD_MAX_W);

  // Sized for the widest supported mantissa; narrower instances use the low bits.
  typedef struct packed {
    logic [LZD_MAX_W-1:0]     data;
    logic [LZD_MAX_CNT_W-1:0] max_shift;
    logic [LZD_MAX_CNT_W-1:0] lz;
    logic                     zero;
  } lzd_payload_t;

endpackage

// File: rtl/fpu_lzd_tree.sv
// Combinational binary-tree leading-zero detector over an arbitrary-width vector.
// Pads to a power of two below the LSB and reports DATA_W for an all-zero input.
module fpu_lzd_tree
  import fpu_lzd_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int CNT_W  = lzd_cnt_w(DATA_W)
) (
  input  logic [DATA_W-1:0] in_data,
  output logic [CNT_W-1:0]  lz,
  output logic              zero
);

  localparam int LVLS = $clog2(DATA_W);
  localparam int PAD_W = 1 << LVLS;

  logic [PAD_W-1:0] padded;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    padded = '0;
    padded[PAD_W-1 -: DATA_W] = in_data;
  end

  // Level k node i covers 2**k bits; v says "holds a one", c counts its leading zeros.
  for (genvar k = 1; k <= LVLS; k++) begin : g_lvl
    localparam int N = PAD_W >> k;
    logic [N-1:0] v;
    logic [k-1:0] c [N];
    for (genvar i = 0; i < N; i++) begin : g_node
      if (k == 1) begin : g_leaf
        assign v[i] = padded[2*i+1] | padded[2*i];
        assign c[i] = ~padded[2*i+1];
      end else begin : g_inner
        assign v[i] = g_lvl[k-1].v[2*i+1] | g_lvl[k-1].v[2*i];
        assign c[i] = g_lvl[k-1].v[2*i+1] ? {1'b0, g_lvl[k-1].c[2*i+1]}
                                          : {1'b1, g_lvl[k-1].c[2*i]};
      end
    end
  end

  // Zero padding sits below the LSB, so only the all-zero case needs correcting.
  assign zero = ~g_lvl[LVLS].v[0];
  assign lz   = zero ? CNT_W'(DATA_W) : CNT_W'(g_lvl[LVLS].c[0]);

endmodule

// File: rtl/fpu_lzd_norm_pipe.sv
// Two-stage LZD + normaliser with valid/ready flow control and flush.
// Define FPU_LZD_NORM_SHIFT_EN to build the barrel shifter; otherwise out_data is 0.
module fpu_lzd_norm_pipe
  import fpu_lzd_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int CNT_W  = lzd_cnt_w(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CNT_W-1:0]  in_max_shift,
  input  logic              in_flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_lz,
  output logic [CNT_W-1:0]  out_shift,
  output logic              out_zero,
  output logic [DATA_W-1:0] out_data
);

  logic             s1_valid;
  logic             s2_valid;
  logic             s2_adv;
  logic             s2_load;
  lzd_payload_t     s1_q;
  logic [CNT_W-1:0] tree_lz;
  logic             tree_zero;
  logic [CNT_W-1:0] s1_lz;
  logic [CNT_W-1:0] s1_max;
  logic [CNT_W-1:0] shift_d;
  logic             unused_pad;

  fpu_lzd_tree #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_tree (
    .in_data (in_data),
    .lz      (tree_lz),
    .zero    (tree_zero)
  );

  assign s2_adv    = !s2_valid || out_ready;
  assign s2_load   = s2_adv && s1_valid;
  assign in_ready  = !s1_valid || s2_adv;
  assign out_valid = s2_valid;

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (in_flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s2_adv) s2_valid <= s1_valid;
      if (in_ready) s1_valid <= in_valid;
    end
  end

  // NOTE: payload registers are reset too, so outputs read 0 after reset rather than X.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
    end else if (in_valid && in_ready) begin
      s1_q.data      <= LZD_MAX_W'(in_data);
      s1_q.max_shift <= LZD_MAX_CNT_W'(in_max_shift);
      s1_q.lz        <= LZD_MAX_CNT_W'(tree_lz);
      s1_q.zero      <= tree_zero;
    end
  end

  assign s1_lz  = s1_q.lz[CNT_W-1:0];
  assign s1_max = s1_q.max_shift[CNT_W-1:0];

  // lz never exceeds DATA_W, so the min also clamps oversized headroom values.
  assign shift_d = (s1_lz < s1_max) ? s1_lz : s1_max;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_lz    <= '0;
      out_shift <= '0;
      out_zero  <= 1'b0;
    end else if (s2_load) begin
      out_lz    <= s1_lz;
      out_shift <= shift_d;
      out_zero  <= s1_q.zero;
    end
  end

`ifdef FPU_LZD_NORM_SHIFT_EN
  logic [DATA_W-1:0] s1_data;

  assign s1_data = s1_q.data[DATA_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data <= '0;
    end else if (s2_load) begin
      out_data <= s1_data << shift_d;
    end
  end
`else
  assign out_data = '0;
`endif

  // Upper payload bits beyond DATA_W/CNT_W are constant and intentionally unread.
  assign unused_pad = ^s1_q;

endmodule

// File: tb/tb_fpu_lzd_norm_pipe.sv
// Self-checking bench: directed cases plus random traffic against a FIFO-style reference.
module tb_fpu_lzd_norm_pipe;

  localparam int DW = 24;
  localparam int CW = 5;
`ifdef FPU_LZD_NORM_SHIFT_EN
  localparam bit SHIFT_EN = 1'b1;
`else
  localparam bit SHIFT_EN = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_max_shift;
  logic          in_flush;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_lz;
  logic [CW-1:0] out_shift;
  logic          out_zero;
  logic [DW-1:0] out_data;

  fpu_lzd_norm_pipe #(.DATA_W(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_max_shift (in_max_shift),
    .in_flush     (in_flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_lz       (out_lz),
    .out_shift    (out_shift),
    .out_zero     (out_zero),
    .out_data     (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [CW-1:0] lz;
    logic [CW-1:0] shift;
    logic          zero;
    int            acc;
  } beat_t;

  beat_t q[$];
  int    cyc;
  int    n_checks;
  int    n_errors;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: count zeros from the MSB, shift = min(lz, headroom), data shifted by it.
  function automatic beat_t model(input logic [DW-1:0] d, input logic [CW-1:0] m);
    beat_t b;
    int    n;
    int    s;
    n = 0;
    while (n < DW && d[DW-1-n] == 1'b0) n++;
    s = (n < int'(m)) ? n : int'(m);
    b.lz    = CW'(n);
    b.shift = CW'(s);
    b.zero  = (d == '0);
    b.data  = SHIFT_EN ? (d << s) : '0;
    b.acc   = 0;
    return b;
  endfunction

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] m,
                       input logic fl, input logic ordy);
    in_valid     = v;
    in_data      = d;
    in_max_shift = m;
    in_flush     = fl;
    out_ready    = ordy;
  endtask

  // Checks handshake and output against the model, then advances one clock.
  task automatic tick();
    logic  exp_rdy;
    logic  exp_v;
    logic  fire;
    logic  acc;
    beat_t b;
    #1;
    exp_rdy = (q.size() < 2) || out_ready;
    exp_v = 1'b0;
    if (q.size() > 0) exp_v = (cyc >= q[0].acc + 1);
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, exp_v);
    if (exp_v) begin
      chk("out_lz", out_lz, q[0].lz);
      chk("out_shift", out_shift, q[0].shift);
      chk("out_zero", out_zero, q[0].zero);
      chk("out_data", out_data, q[0].data);
    end
    fire = exp_v && out_ready;
    acc  = in_valid && exp_rdy && !in_flush;
    if (fire) void'(q.pop_front());
    if (in_flush) begin
      q.delete();
    end else if (acc) begin
      b = model(in_data, in_max_shift);
      b.acc = cyc + 1;
      q.push_back(b);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] m,
                       input logic fl, input logic ordy);
    drive(v, d, m, fl, ordy);
    tick();
  endtask

  task automatic expect_out(input string tag, input logic [CW-1:0] lz, input logic [CW-1:0] sh,
                            input logic z, input logic [DW-1:0] d);
    #1;
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_lz"}, out_lz, lz);
    chk({tag, "_shift"}, out_shift, sh);
    chk({tag, "_zero"}, out_zero, z);
    chk({tag, "_data"}, out_data, SHIFT_EN ? d : '0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc = 0;
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b1);

    // Reset state
    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_lz", out_lz, '0);
    chk("rst_out_shift", out_shift, '0);
    chk("rst_out_zero", out_zero, 1'b0);
    chk("rst_out_data", out_data, '0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1'b1);

    // Directed values
    cycle(1'b1, 24'h000001, 5'd31, 1'b0, 1'b1);
    cycle(1'b0, '0, '0, 1'b0, 1'b1);
    expect_out("lsb_one", 5'd23, 5'd23, 1'b0, 24'h800000);
    cycle(1'b1, 24'h000000, 5'd10, 1'b0, 1'b1);
    cycle(1'b0, '0, '0, 1'b0, 1'b1);
    expect_out("zero_in", 5'd24, 5'd10, 1'b1, 24'h000000);
    cycle(1'b1, 24'h000100, 5'd5, 1'b0, 1'b1);
    cycle(1'b0, '0, '0, 1'b0, 1'b1);
    expect_out("clamped", 5'd15, 5'd5, 1'b0, 24'h002000);
    cycle(1'b1, 24'h800000, 5'd5, 1'b0, 1'b1);
    cycle(1'b0, '0, '0, 1'b0, 1'b1);
    expect_out("msb_one", 5'd0, 5'd0, 1'b0, 24'h800000);
    cycle(1'b0, '0, '0, 1'b0, 1'b1);

    // Backpressure: A, B fill the pipe, C is held off while out_ready is low
    cycle(1'b1, 24'h00F00F, 5'd31, 1'b0, 1'b0);
    cycle(1'b1, 24'h000A5A, 5'd7, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 24'h03C000, 5'd2, 1'b0, 1'b0);
      #1;
      chk("bp_in_ready_low", in_ready, 1'b0);
      tick();
    end
    cycle(1'b1, 24'h03C000, 5'd2, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, '0, 1'b0, 1'b1);

    // Flush with both stages full and a beat offered, then with in_ready high
    cycle(1'b1, 24'h123456, 5'd3, 1'b0, 1'b0);
    cycle(1'b1, 24'h00FFFF, 5'd20, 1'b0, 1'b0);
    cycle(1'b1, 24'h000777, 5'd20, 1'b1, 1'b0);
    #1;
    chk("flush_out_valid", out_valid, 1'b0);
    cycle(1'b1, 24'h0000F0, 5'd20, 1'b1, 1'b1);
    cycle(1'b1, 24'h001000, 5'd31, 1'b0, 1'b1);
    cycle(1'b0, '0, '0, 1'b0, 1'b1);
    expect_out("post_flush", 5'd11, 5'd11, 1'b0, 24'h800000);
    cycle(1'b0, '0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, '0, 1'b0, 1'b1);

    // Asynchronous reset mid-stream
    cycle(1'b1, 24'h0F0000, 5'd31, 1'b0, 1'b0);
    cycle(1'b1, 24'h000003, 5'd31, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", out_valid, 1'b0);
    q.delete();
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_release_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b0, 1'b1);

    // Random traffic with stalls and occasional flush
    for (int i = 0; i < 600; i++) begin
      logic [DW-1:0] d;
      d = DW'($urandom) >> $urandom_range(0, 25);
      cycle(($urandom % 3) != 0, d, CW'($urandom_range(0, 31)),
            ($urandom % 25) == 0, ($urandom % 4) != 0);
    end
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, '0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
